painterengine_gpu_dmareader: RTL and testbench
==============================================

PAINTERENGINE_GPU_DMAREADER -- requirements
Module: painterengine_gpu_dmareader

Interface
REQ-001 The block SHALL have parameter PARAM_MAX_BURST, default 16, meaning maximum beats per AXI read burst (power of two, 1..256).
REQ-002 The block SHALL have port i_wire_clock  input  1  sole clock; all logic is on its rising edge.
REQ-003 The block SHALL have port i_wire_reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port i_wire_enable  input  1  run request from the display stage; low means close the reader or abort it.
REQ-005 The block SHALL have ports i_wire_address  input  32  start byte address, and i_wire_length  input  32  transfer length in 32-bit words.
REQ-006 The block SHALL have ports o_wire_done  output  1  transfer complete, and o_wire_error  output  1  transfer failed.
REQ-007 The block SHALL have ports o_wire_data  output  32  pixel word, o_wire_data_valid  output  1  word transferred this cycle, and i_wire_data_next  input  1  sink can accept a word.
REQ-008 The block SHALL have AXI4 read-address ports o_wire_axi_araddr (output, 32), o_wire_axi_arlen (output, 8), o_wire_axi_arsize (output, 3), o_wire_axi_arburst (output, 2), o_wire_axi_arvalid (output, 1) and i_wire_axi_arready (input, 1).
REQ-009 The block SHALL have AXI4 read-data ports i_wire_axi_rdata (input, 32), i_wire_axi_rresp (input, 2), i_wire_axi_rlast (input, 1), i_wire_axi_rvalid (input, 1) and o_wire_axi_rready (output, 1).

Function
REQ-010 The state machine SHALL have the states IDLE, ADDR, DATA, DRAIN, DONE and ERROR.
REQ-011 IDLE, on enable=1: latch address and length; length=0 -> DONE; address[1:0]!=0 -> ERROR; otherwise -> ADDR.
REQ-012 ADDR: the block SHALL compute beats = min(remaining, PARAM_MAX_BURST, (4096-addr[11:0])>>2), drive arlen=beats-1, drive arvalid=1, and on arready go to DATA.
REQ-013 Bursts SHALL never cross a 4 KB boundary, and araddr SHALL advance by beats*4 per burst.
REQ-014 arsize SHALL be constant 3'b010 and arburst SHALL be constant 2'b01 (INCR).
REQ-015 Once asserted, arvalid SHALL stay high with araddr and arlen stable until arready, even if enable drops.
REQ-016 DATA: rready SHALL be i_wire_data_next, o_wire_data SHALL be rdata, and data_valid SHALL be rvalid&&rready, all combinational with zero latency.
REQ-017 Each accepted beat SHALL decrement remaining by 1 and the burst beat counter by 1.
REQ-018 On the last beat of a burst, the block SHALL go to DONE if remaining reaches 0, else to ADDR.
REQ-019 An accepted beat with rresp!=2'b00, or rlast mismatching the beat counter, SHALL latch the error flag; that beat's data_valid SHALL still be 1, and the block SHALL go to DRAIN, or to ERROR if the beat was the final one.
REQ-020 If enable=0 in DATA, or in ADDR after the handshake, the block SHALL go to DRAIN.
REQ-021 DRAIN: rready SHALL be 1 and data_valid SHALL be 0, and on an accepted rlast the block SHALL go to ERROR if error is latched, else to IDLE.
REQ-022 If enable=0 in ADDR before arready, the block SHALL complete the address handshake and then enter DRAIN.
REQ-023 DONE SHALL hold o_wire_done=1, and ERROR SHALL hold o_wire_error=1, while enable=1; either state SHALL return to IDLE one cycle after enable=0.
REQ-024 done and error SHALL be registered outputs and SHALL never both be 1.
REQ-025 Address and length inputs SHALL be ignored outside IDLE.
REQ-026 Remaining SHALL be 32-bit, and the address SHALL wrap modulo 2^32 without error.

Reset
REQ-027 While i_wire_reset=1 at a clock edge: state=IDLE, arvalid=0, rready=0, done=0, error=0, data_valid=0, araddr=0, arlen=0, remaining=0, error flag cleared.
REQ-028 Reset SHALL take priority over enable, and the AXI interconnect SHALL be reset in the same cycle.

Verification
REQ-029 Directed test, basic read: addr=0x1000, len=48, PARAM_MAX_BURST=16, arready and rvalid always 1 -> bursts at 0x1000/0x1040/0x1080 with arlen=15, 48 data_valid pulses, done=1 one cycle after the final beat.
REQ-030 Directed test, 4 KB split: addr=0x1FF8, len=10 -> bursts at 0x1FF8 with arlen=1 and at 0x2000 with arlen=7; done=1.
REQ-031 Directed test, backpressure: data_next toggles every cycle, len=4 -> rready mirrors data_next, exactly 4 data_valid pulses, data order preserved.
REQ-032 Directed test, abort: enable dropped after beat 3 of a 16-beat burst -> remaining 13 beats drained with data_valid=0, then IDLE, done=0.
REQ-033 Directed test, slave error: rresp=2'b10 on beat 2 of len=8 -> drain to rlast, then error=1 and done=0; IDLE one cycle after enable=0.
REQ-034 Directed test, edge cases: len=0 -> done the next cycle with no AR handshake; addr=0x1002 -> error with no AR handshake.

Source files
------------

// File: rtl/painterengine_gpu_dmareader.sv
// AXI4 read-burst DMA front end for the display path: splits a word-count
// transfer into 4 KB-safe INCR bursts and streams beats to a pixel sink.
module painterengine_gpu_dmareader #(
  parameter int PARAM_MAX_BURST = 16
) (
  input  logic        i_wire_clock,
  input  logic        i_wire_reset,
  input  logic        i_wire_enable,
  input  logic [31:0] i_wire_address,
  input  logic [31:0] i_wire_length,
  output logic        o_wire_done,
  output logic        o_wire_error,
  output logic [31:0] o_wire_data,
  output logic        o_wire_data_valid,
  input  logic        i_wire_data_next,
  output logic [31:0] o_wire_axi_araddr,
  output logic [7:0]  o_wire_axi_arlen,
  output logic [2:0]  o_wire_axi_arsize,
  output logic [1:0]  o_wire_axi_arburst,
  output logic        o_wire_axi_arvalid,
  input  logic        i_wire_axi_arready,
  input  logic [31:0] i_wire_axi_rdata,
  input  logic [1:0]  i_wire_axi_rresp,
  input  logic        i_wire_axi_rlast,
  input  logic        i_wire_axi_rvalid,
  output logic        o_wire_axi_rready,
  output logic [2:0]  o_wire_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // a raised arvalid holds araddr/arlen stable until arready is seen.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  localparam logic [10:0] MAX_W = 11'(PARAM_MAX_BURST);

  state_t      state;
  logic [31:0] next_addr;
  logic [31:0] remaining;
  logic [8:0]  beat_cnt;
  logic        err_flag;

  logic [8:0]  first_beats;
  logic [8:0]  cont_beats;
  logic        beat;
  logic        beat_bad;

  // Beats for one burst: limited by words left, the burst cap and the
  // words remaining before the next 4 KB page boundary.
  function automatic logic [8:0] calc_beats(input logic [9:0] word_off,
                                            input logic [31:0] rem);
    logic [10:0] room;
    logic [8:0]  cap;
    room = 11'd1024 - {1'b0, word_off};
    cap  = (room > MAX_W) ? MAX_W[8:0] : room[8:0];
    if (rem < {23'd0, cap}) return rem[8:0];
    return cap;
  endfunction

  assign first_beats = calc_beats(i_wire_address[11:2], i_wire_length);
  assign cont_beats  = calc_beats(next_addr[11:2], remaining - 32'd1);

  assign o_wire_axi_arsize  = 3'b010;
  assign o_wire_axi_arburst = 2'b01;
  assign o_wire_state       = state;
  assign o_wire_data        = i_wire_axi_rdata;

  always_comb begin
    o_wire_axi_rready = 1'b0;
    if (!i_wire_reset) begin
      if (state == S_DATA)       o_wire_axi_rready = i_wire_data_next;
      else if (state == S_DRAIN) o_wire_axi_rready = 1'b1;
    end
  end

  assign beat              = i_wire_axi_rvalid && o_wire_axi_rready;
  assign o_wire_data_valid = beat && (state == S_DATA);
  assign beat_bad          = (i_wire_axi_rresp != 2'b00) ||
                             (i_wire_axi_rlast != (beat_cnt == 9'd1));

  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset) begin
      state              <= S_IDLE;
      o_wire_axi_arvalid <= 1'b0;
      o_wire_axi_araddr  <= 32'd0;
      o_wire_axi_arlen   <= 8'd0;
      next_addr          <= 32'd0;
      remaining          <= 32'd0;
      beat_cnt           <= 9'd0;
      err_flag           <= 1'b0;
      o_wire_done        <= 1'b0;
      o_wire_error       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          o_wire_done  <= 1'b0;
          o_wire_error <= 1'b0;
          err_flag     <= 1'b0;
          if (i_wire_enable) begin
            next_addr <= i_wire_address;
            remaining <= i_wire_length;
            if (i_wire_length == 32'd0) begin
              state       <= S_DONE;
              o_wire_done <= 1'b1;
            end else if (i_wire_address[1:0] != 2'b00) begin
              state        <= S_ERROR;
              o_wire_error <= 1'b1;
            end else begin
              state              <= S_ADDR;
              o_wire_axi_arvalid <= 1'b1;
              o_wire_axi_araddr  <= i_wire_address;
              o_wire_axi_arlen   <= first_beats[7:0] - 8'd1;
              beat_cnt           <= first_beats;
            end
          end
        end

        // Enable is deliberately ignored until the address handshake ends.
        S_ADDR: begin
          if (i_wire_axi_arready) begin
            o_wire_axi_arvalid <= 1'b0;
            next_addr <= o_wire_axi_araddr + {21'd0, beat_cnt, 2'b00};
            state     <= i_wire_enable ? S_DATA : S_DRAIN;
          end
        end

        S_DATA: begin
          if (beat) begin
            remaining <= remaining - 32'd1;
            beat_cnt  <= beat_cnt - 9'd1;
            if (beat_bad) begin
              err_flag <= 1'b1;
              if (i_wire_axi_rlast) begin
                state        <= S_ERROR;
                o_wire_error <= 1'b1;
              end else begin
                state <= S_DRAIN;
              end
            end else if (beat_cnt == 9'd1) begin
              if (remaining == 32'd1) begin
                state       <= S_DONE;
                o_wire_done <= 1'b1;
              end else if (!i_wire_enable) begin
                // Burst fully received, nothing outstanding to drain.
                state <= S_IDLE;
              end else begin
                state              <= S_ADDR;
                o_wire_axi_arvalid <= 1'b1;
                o_wire_axi_araddr  <= next_addr;
                o_wire_axi_arlen   <= cont_beats[7:0] - 8'd1;
                beat_cnt           <= cont_beats;
              end
            end else if (!i_wire_enable) begin
              state <= S_DRAIN;
            end
          end else if (!i_wire_enable) begin
            state <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (i_wire_axi_rvalid && i_wire_axi_rlast) begin
            if (err_flag) begin
              state        <= S_ERROR;
              o_wire_error <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end

        S_DONE: begin
          if (!i_wire_enable) begin
            state       <= S_IDLE;
            o_wire_done <= 1'b0;
          end
        end

        S_ERROR: begin
          if (!i_wire_enable) begin
            state        <= S_IDLE;
            o_wire_error <= 1'b0;
          end
        end

        default: begin
          state              <= S_IDLE;
          o_wire_axi_arvalid <= 1'b0;
          o_wire_done        <= 1'b0;
          o_wire_error       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_painterengine_gpu_dmareader.sv
// Directed bench for painterengine_gpu_dmareader with a small AXI read slave
// whose data word equals the byte address of the beat.
module tb_painterengine_gpu_dmareader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] length = 32'd0;
  logic        done, error;
  logic [31:0] data;
  logic        data_valid;
  logic        data_next = 1'b1;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic [1:0]  rresp = 2'b00;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [2:0]  state;

  painterengine_gpu_dmareader #(.PARAM_MAX_BURST(16)) dut (
    .i_wire_clock(clk), .i_wire_reset(reset), .i_wire_enable(enable),
    .i_wire_address(address), .i_wire_length(length),
    .o_wire_done(done), .o_wire_error(error),
    .o_wire_data(data), .o_wire_data_valid(data_valid), .i_wire_data_next(data_next),
    .o_wire_axi_araddr(araddr), .o_wire_axi_arlen(arlen), .o_wire_axi_arsize(arsize),
    .o_wire_axi_arburst(arburst), .o_wire_axi_arvalid(arvalid), .i_wire_axi_arready(arready),
    .i_wire_axi_rdata(rdata), .i_wire_axi_rresp(rresp), .i_wire_axi_rlast(rlast),
    .i_wire_axi_rvalid(rvalid), .o_wire_axi_rready(rready), .o_wire_state(state)
  );

  // clock / reset block
  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // stimulus-side controls (written only by the main sequence)
  bit toggle_next = 1'b0;
  bit ar_en = 1'b1;
  int err_beat = -1;

  // monitor / scoreboard state (written only by the monitor)
  logic [31:0] got_q[$];
  logic [31:0] ara_q[$];
  logic [7:0]  arl_q[$];
  int cyc = 0;
  int last_beat_cyc = 0;
  int rhs_cnt = 0;
  int rr_viol = 0;
  int ar_viol = 0;

  // expected queue (main sequence only)
  logic [31:0] exp_q[$];
  int done_cyc = 0;

  // AXI read slave: bursts queued in order, data = beat byte address
  logic [31:0] b_addr_q[$];
  logic [7:0]  b_len_q[$];
  int beat_idx = 0;
  int gbeat = 0;

  initial begin
    bit ar_f, r_f;
    logic [31:0] cap_a;
    logic [7:0]  cap_l;
    forever begin
      @(negedge clk);
      ar_f  = arvalid && arready;
      r_f   = rvalid && rready;
      cap_a = araddr;
      cap_l = arlen;
      @(posedge clk);
      #1;
      if (reset) begin
        b_addr_q.delete();
        b_len_q.delete();
        beat_idx = 0;
      end else begin
        if (r_f && b_addr_q.size() > 0) begin
          gbeat++;
          if (beat_idx == int'(b_len_q[0])) begin
            void'(b_addr_q.pop_front());
            void'(b_len_q.pop_front());
            beat_idx = 0;
          end else begin
            beat_idx++;
          end
        end
        if (ar_f) begin
          b_addr_q.push_back(cap_a);
          b_len_q.push_back(cap_l);
        end
      end
      arready = ar_en;
      if (b_addr_q.size() > 0) begin
        rvalid = 1'b1;
        rdata  = b_addr_q[0] + 32'(beat_idx * 4);
        rlast  = (beat_idx == int'(b_len_q[0]));
        rresp  = (gbeat == err_beat) ? 2'b10 : 2'b00;
      end else begin
        rvalid = 1'b0;
        rdata  = 32'd0;
        rlast  = 1'b0;
        rresp  = 2'b00;
      end
    end
  end

  // monitor: samples on the falling edge, between drive and capture
  initial begin
    bit ar_pend;
    logic [31:0] pa;
    logic [7:0]  pl;
    ar_pend = 1'b0;
    pa = 32'd0;
    pl = 8'd0;
    forever begin
      @(negedge clk);
      cyc++;
      if (data_valid) begin
        got_q.push_back(data);
        last_beat_cyc = cyc;
      end
      if (rvalid && rready) rhs_cnt++;
      if (arvalid && arready) begin
        ara_q.push_back(araddr);
        arl_q.push_back(arlen);
      end
      if (state == 3'd2 && rready !== data_next) rr_viol++;
      if (ar_pend && (!arvalid || araddr != pa || arlen != pl)) ar_viol++;
      ar_pend = arvalid && !arready;
      pa = araddr;
      pl = arlen;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // driver: one cycle; inputs change 2 time units after the edge, sampling at +3
  task automatic tick();
    @(posedge clk);
    #2;
    if (toggle_next) data_next = ~data_next;
    #1;
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] l);
    address = a;
    length  = l;
    enable  = 1'b1;
  endtask

  // kind: 0 done, 1 idle, 2 error, 3 beats received >= target
  task automatic wait_until(input int kind, input int target, input int limit, input string tag);
    bit met;
    int n;
    met = 1'b0;
    n = 0;
    while (!met && n < limit) begin
      tick();
      n++;
      case (kind)
        0: met = (done === 1'b1);
        1: met = (state === 3'd0);
        2: met = (error === 1'b1);
        default: met = (got_q.size() >= target);
      endcase
      if (kind == 0 && met) done_cyc = cyc;
    end
    chk({tag, "_timeout"}, 32'(met), 32'd1);
  endtask

  task automatic check_data(input string tag, input int gb);
    chk({tag, "_count"}, 32'(got_q.size() - gb), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && gb + k < got_q.size(); k++)
      chk($sformatf("%s_d%0d", tag, k), got_q[gb + k], exp_q[k]);
    exp_q.delete();
  endtask

  task automatic check_ar(input string tag, input int ab, input int idx,
                          input logic [31:0] ea, input logic [7:0] el);
    if (ab + idx < ara_q.size()) begin
      chk($sformatf("%s_araddr%0d", tag, idx), ara_q[ab + idx], ea);
      chk($sformatf("%s_arlen%0d", tag, idx), 32'(arl_q[ab + idx]), 32'(el));
    end else begin
      chk($sformatf("%s_ar%0d_present", tag, idx), 32'(ara_q.size() - ab), 32'(idx + 1));
    end
  endtask

  task automatic close_idle(input string tag);
    enable = 1'b0;
    tick();
    chk({tag, "_idle"}, 32'(state), 32'd0);
    chk({tag, "_done_low"}, 32'(done), 32'd0);
    chk({tag, "_error_low"}, 32'(error), 32'd0);
  endtask

  initial begin
    int gb, ab, rb;

    // reset has priority over a concurrent enable
    start(32'h0000_1000, 32'd4);
    tick();
    tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_data_valid", 32'(data_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_arlen", 32'(arlen), 32'd0);
    chk("arsize", 32'(arsize), 32'd2);
    chk("arburst", 32'(arburst), 32'd1);
    enable = 1'b0;
    reset = 1'b0;
    tick();

    // basic read: three 16-beat bursts; inputs changed mid-run are ignored
    gb = got_q.size(); ab = ara_q.size();
    start(32'h0000_1000, 32'd48);
    tick();
    chk("basic_arvalid", 32'(arvalid), 32'd1);
    address = 32'hDEAD_0000;
    length  = 32'd7;
    wait_until(0, 0, 200, "basic_done");
    chk("basic_done_latency", 32'(done_cyc), 32'(last_beat_cyc));
    chk("basic_error", 32'(error), 32'd0);
    chk("basic_ar_count", 32'(ara_q.size() - ab), 32'd3);
    check_ar("basic", ab, 0, 32'h0000_1000, 8'd15);
    check_ar("basic", ab, 1, 32'h0000_1040, 8'd15);
    check_ar("basic", ab, 2, 32'h0000_1080, 8'd15);
    for (int i = 0; i < 48; i++) exp_q.push_back(32'h0000_1000 + 32'(4 * i));
    check_data("basic", gb);
    close_idle("basic");

    // 4 KB split: 2 beats up to the page end, then 8 beats
    gb = got_q.size(); ab = ara_q.size();
    start(32'h0000_1FF8, 32'd10);
    wait_until(0, 0, 100, "split_done");
    chk("split_ar_count", 32'(ara_q.size() - ab), 32'd2);
    check_ar("split", ab, 0, 32'h0000_1FF8, 8'd1);
    check_ar("split", ab, 1, 32'h0000_2000, 8'd7);
    for (int i = 0; i < 10; i++) exp_q.push_back(32'h0000_1FF8 + 32'(4 * i));
    check_data("split", gb);
    close_idle("split");

    // address wraps through zero without error
    gb = got_q.size(); ab = ara_q.size();
    start(32'hFFFF_FFF8, 32'd4);
    wait_until(0, 0, 100, "wrap_done");
    chk("wrap_error", 32'(error), 32'd0);
    check_ar("wrap", ab, 0, 32'hFFFF_FFF8, 8'd1);
    check_ar("wrap", ab, 1, 32'h0000_0000, 8'd1);
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0004);
    check_data("wrap", gb);
    close_idle("wrap");

    // backpressure: sink ready toggles every cycle
    gb = got_q.size();
    toggle_next = 1'b1;
    start(32'h0000_2000, 32'd4);
    wait_until(0, 0, 100, "bp_done");
    toggle_next = 1'b0;
    data_next = 1'b1;
    chk("bp_rready_mirror", 32'(rr_viol), 32'd0);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h0000_2000 + 32'(4 * i));
    check_data("bp", gb);
    close_idle("bp");

    // abort after beat 3 of a 16-beat burst: the rest drains silently
    gb = got_q.size(); ab = ara_q.size(); rb = rhs_cnt;
    start(32'h0000_6000, 32'd32);
    wait_until(3, gb + 3, 100, "abort_beats");
    enable = 1'b0;
    data_next = 1'b0;
    tick();
    chk("abort_drain_state", 32'(state), 32'd3);
    chk("abort_drain_rready", 32'(rready), 32'd1);
    data_next = 1'b1;
    wait_until(1, 0, 100, "abort_idle");
    chk("abort_beats_seen", 32'(got_q.size() - gb), 32'd3);
    chk("abort_beats_drained", 32'(rhs_cnt - rb), 32'd16);
    chk("abort_ar_count", 32'(ara_q.size() - ab), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_slave_empty", 32'(b_addr_q.size()), 32'd0);

    // abort while arvalid is waiting: handshake completes, then drain
    gb = got_q.size(); ab = ara_q.size(); rb = rhs_cnt;
    ar_en = 1'b0;
    tick();
    start(32'h0000_5000, 32'd4);
    tick();
    tick();
    tick();
    chk("arwait_arvalid", 32'(arvalid), 32'd1);
    chk("arwait_araddr", araddr, 32'h0000_5000);
    chk("arwait_arlen", 32'(arlen), 32'd3);
    enable = 1'b0;
    tick();
    tick();
    chk("arwait_hold_arvalid", 32'(arvalid), 32'd1);
    chk("arwait_hold_state", 32'(state), 32'd1);
    ar_en = 1'b1;
    wait_until(1, 0, 100, "arwait_idle");
    chk("arwait_beats_drained", 32'(rhs_cnt - rb), 32'd4);
    chk("arwait_beats_seen", 32'(got_q.size() - gb), 32'd0);
    chk("arwait_ar_count", 32'(ara_q.size() - ab), 32'd1);
    chk("arwait_stable", 32'(ar_viol), 32'd0);
    chk("arwait_done", 32'(done), 32'd0);

    // slave error on the second beat: that beat still delivered, then drain
    gb = got_q.size(); rb = rhs_cnt;
    err_beat = gbeat + 1;
    start(32'h0000_3000, 32'd8);
    wait_until(2, 0, 100, "slverr_error");
    err_beat = -1;
    chk("slverr_done", 32'(done), 32'd0);
    chk("slverr_state", 32'(state), 32'd5);
    chk("slverr_beats_drained", 32'(rhs_cnt - rb), 32'd8);
    exp_q.push_back(32'h0000_3000);
    exp_q.push_back(32'h0000_3004);
    check_data("slverr", gb);
    tick();
    chk("slverr_error_held", 32'(error), 32'd1);
    close_idle("slverr");

    // zero length: done next cycle, no address handshake
    ab = ara_q.size();
    start(32'h0000_4000, 32'd0);
    tick();
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_error", 32'(error), 32'd0);
    chk("len0_arvalid", 32'(arvalid), 32'd0);
    close_idle("len0");
    chk("len0_ar_count", 32'(ara_q.size() - ab), 32'd0);

    // misaligned start: error next cycle, no address handshake
    ab = ara_q.size();
    start(32'h0000_1002, 32'd5);
    tick();
    chk("misalign_error", 32'(error), 32'd1);
    chk("misalign_done", 32'(done), 32'd0);
    chk("misalign_arvalid", 32'(arvalid), 32'd0);
    close_idle("misalign");
    chk("misalign_ar_count", 32'(ara_q.size() - ab), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
